serial_rx_sync: RTL

SERIAL_RX_SYNC -- requirements
Module: serial_rx_sync

---
 rtl/serial_rx_sync_pkg.sv | 12 +
 rtl/serial_rx_sync_symbol_detect.sv | 32 +++
 rtl/serial_rx_sync.sv | 133 +++++++++++++
 3 files changed

// File: rtl/serial_rx_sync_pkg.sv
// rtl/serial_rx_sync_pkg.sv - symbol constants and receiver state encoding shared with the transmitter
package serial_rx_sync_pkg;
  localparam logic [7:0] COM      = 8'hBC;
  localparam logic [7:0] IDL      = 8'h7C;
  localparam logic [2:0] COM_LOCK = 3'd4;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } rx_state_e;
endpackage

// File: rtl/serial_rx_sync_symbol_detect.sv
// rtl/serial_rx_sync_symbol_detect.sv - serial shift register and COM/IDL window compare
module symbol_detect
  import serial_rx_sync_pkg::*;
(
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] w,
  output logic       is_com,
  output logic       is_idl
);

  // The oldest shifted bit never reaches the window, so only seven are kept.
  logic [6:0] sr_q, sr_d;

  assign w      = {sr_q, serial_in};
  assign is_com = (w == COM);
  assign is_idl = (w == IDL);

  always_comb begin
    sr_d = w[6:0];
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/serial_rx_sync.sv
// rtl/serial_rx_sync.sv - COM-aligned byte receiver for one PHY lane
// Optional RX_BYTE_CNT_EN adds rx_count, a saturating count of delivered bytes.
module serial_rx_sync
  import serial_rx_sync_pkg::*;
(
  input  logic        clk_32f,
  input  logic        reset,
  input  logic        serial_in,
  input  logic        sincronizar_bus,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        active
`ifdef RX_BYTE_CNT_EN
  ,
  output logic [15:0] rx_count
`endif
);

  logic [7:0] w;
  logic       is_com, is_idl, boundary;
  rx_state_e  state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] com_cnt_q, com_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       active_q, active_d;

  symbol_detect u_symbol_detect (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .serial_in (serial_in),
    .w         (w),
    .is_com    (is_com),
    .is_idl    (is_idl)
  );

  assign boundary = (bit_cnt_q == 3'd7);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q + 3'd1;
    com_cnt_d = com_cnt_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    active_d  = active_q;
    // Resync outranks everything, including a lock or byte completing this cycle.
    if (sincronizar_bus) begin
      state_d   = SEARCH;
      bit_cnt_d = '0;
      com_cnt_d = '0;
      active_d  = 1'b0;
    end else begin
      case (state_q)
        SEARCH: begin
          if (is_com) begin
            bit_cnt_d = '0;
            com_cnt_d = 3'd1;
            state_d   = ALIGN;
          end
        end
        ALIGN: begin
          if (boundary) begin
            if (is_com) begin
              com_cnt_d = com_cnt_q + 3'd1;
              if (com_cnt_d == COM_LOCK) begin
                state_d  = LOCKED;
                active_d = 1'b1;
              end
            end else begin
              state_d   = SEARCH;
              com_cnt_d = '0;
            end
          end
        end
        LOCKED: begin
          if (boundary && !is_com && !is_idl) begin
            data_d  = w;
            valid_d = 1'b1;
          end
        end
        default: begin
          state_d = SEARCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q   <= SEARCH;
      bit_cnt_q <= '0;
      com_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active    = active_q;

`ifdef RX_BYTE_CNT_EN
  logic [15:0] rx_count_q, rx_count_d;

  always_comb begin
    rx_count_d = rx_count_q;
    if (sincronizar_bus) begin
      rx_count_d = '0;
    end else if (valid_d && rx_count_q != 16'hFFFF) begin
      rx_count_d = rx_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      rx_count_q <= '0;
    end else begin
      rx_count_q <= rx_count_d;
    end
  end

  assign rx_count = rx_count_q;
`endif

endmodule
